// File: rtl/mult_div_unit_pkg.sv
// Shared constants and state encoding for the iterative multiply/divide unit.
package mult_div_unit_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITERS = MD_WIDTH;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/mult_div_unit_div_core.sv
// Restoring divider on operand magnitudes; one quotient bit per step, with
// sign correction applied to the post-step values so the top can capture them.
module mult_div_unit_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic             rem_neg_reg;
    logic             quo_neg_reg;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;

    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude.
    assign dividend_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign divisor_mag  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;

    always_comb begin
        shifted  = {rem_reg, quo_reg[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_reg};
        fits     = ~trial[WIDTH];
        rem_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo_reg[WIDTH-2:0], fits};
    end

    assign quotient  = quo_neg_reg ? (~quo_next + 1'b1) : quo_next;
    assign remainder = rem_neg_reg ? (~rem_next + 1'b1) : rem_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_reg     <= '0;
            quo_reg     <= '0;
            dvs_reg     <= '0;
            rem_neg_reg <= 1'b0;
            quo_neg_reg <= 1'b0;
        end else if (load) begin
            rem_reg     <= '0;
            quo_reg     <= dividend_mag;
            dvs_reg     <= divisor_mag;
            rem_neg_reg <= dividend[WIDTH-1];
            quo_neg_reg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        end else if (step) begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit with a
// start/busy/done handshake and a 64-bit HI/LO result.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    md_state_t        state_reg;
    logic [CNT_W-1:0] counter_reg;

    // Booth register {acc, mq, q1}; acc carries one guard bit so that
    // subtracting the most negative multiplicand cannot overflow.
    logic [WIDTH:0]   acc_reg;
    logic [WIDTH-1:0] mq_reg;
    logic             q1_reg;
    logic [WIDTH-1:0] mcand_reg;

    logic [WIDTH:0]   mcand_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   acc_next;
    logic [WIDTH-1:0] mq_next;

    logic             accept_mult;
    logic             accept_div;
    logic             div_load;
    logic             div_step;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;

    assign accept_mult = (state_reg == MD_IDLE) && start_mult;
    assign accept_div  = (state_reg == MD_IDLE) && !start_mult && start_div;
    assign div_load    = accept_div && (op_b != '0);
    assign div_step    = (state_reg == MD_DIV);

    always_comb begin
        mcand_ext = {mcand_reg[WIDTH-1], mcand_reg};
        case ({mq_reg[0], q1_reg})
            2'b01:   booth_sum = acc_reg + mcand_ext;
            2'b10:   booth_sum = acc_reg - mcand_ext;
            default: booth_sum = acc_reg;
        endcase
        acc_next = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        mq_next  = {booth_sum[0], mq_reg[WIDTH-1:1]};
    end

    mult_div_unit_div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .step      (div_step),
        .dividend  (op_a),
        .divisor   (op_b),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= MD_IDLE;
            counter_reg <= '0;
            acc_reg     <= '0;
            mq_reg      <= '0;
            q1_reg      <= 1'b0;
            mcand_reg   <= '0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_zero    <= 1'b0;
        end else begin
            case (state_reg)
                MD_IDLE: begin
                    counter_reg <= '0;
                    if (accept_mult) begin
                        acc_reg   <= '0;
                        mq_reg    <= op_b;
                        q1_reg    <= 1'b0;
                        mcand_reg <= op_a;
                        busy      <= 1'b1;
                        state_reg <= MD_MULT;
                    end else if (accept_div) begin
                        if (op_b == '0) begin
                            done      <= 1'b1;
                            div_zero  <= 1'b1;
                            state_reg <= MD_DONE;
                        end else begin
                            busy      <= 1'b1;
                            state_reg <= MD_DIV;
                        end
                    end
                end
                MD_MULT: begin
                    acc_reg     <= acc_next;
                    mq_reg      <= mq_next;
                    q1_reg      <= mq_reg[0];
                    counter_reg <= counter_reg + 1'b1;
                    if (counter_reg == LAST_ITER) begin
                        hi        <= acc_next[WIDTH-1:0];
                        lo        <= mq_next;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= MD_DONE;
                    end
                end
                MD_DIV: begin
                    counter_reg <= counter_reg + 1'b1;
                    if (counter_reg == LAST_ITER) begin
                        hi        <= div_remainder;
                        lo        <= div_quotient;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    done        <= 1'b0;
                    div_zero    <= 1'b0;
                    counter_reg <= '0;
                    state_reg   <= MD_IDLE;
                end
                default: state_reg <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed results, latency, handshake
// and asynchronous reset behaviour.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .op_a       (op_a),
        .op_b       (op_b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, then follow it to completion and a quiet tail.
    task automatic run_op(input string tag, input logic do_mult, input logic do_div,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz, input int exp_lat, input int inject_cyc);
        int lat;
        int busy_cnt;
        int extra_done;
        lat = 0;
        busy_cnt = 0;
        extra_done = 0;
        @(negedge clk);
        op_a = a;
        op_b = b;
        start_mult = do_mult;
        start_div = do_div;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        start_div = 1'b0;
        op_a = 32'hDEAD_BEEF;
        op_b = 32'h0000_0003;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start_div = (cyc == inject_cyc);
            if (busy) busy_cnt++;
            if (busy && done) extra_done++;
            if (done) begin
                lat = cyc;
                break;
            end
        end
        start_div = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy_cycles"}, 64'(busy_cnt), exp_dz ? 64'd0 : 64'd32);
        check({tag, " busy_with_done"}, 64'(extra_done), 64'd0);
        check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
        check({tag, " div_zero"}, {63'd0, div_zero}, {63'd0, exp_dz});
        extra_done = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check({tag, " single_done"}, 64'(extra_done), 64'd0);
    endtask

    initial begin
        int dones;
        reset = 1'b1;
        start_mult = 1'b0;
        start_div = 1'b0;
        op_a = '0;
        op_b = '0;
        repeat (3) @(negedge clk);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        check("reset flags", {61'd0, busy, done, div_zero}, 64'd0);
        reset = 1'b0;

        run_op("mult 7*-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 0);
        run_op("div 7/-2", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33, 0);
        run_op("div -7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 0);
        run_op("div ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33, 0);
        run_op("mult min*min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33, 0);
        run_op("div by zero", 1'b0, 1'b1, 32'd55, 32'd0, 32'h4000_0000, 32'h0000_0000, 1'b1, 1, 0);
        run_op("mult mid start", 1'b1, 1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 33, 6);
        run_op("mult+div both", 1'b1, 1'b1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33, 0);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        op_a = 32'h0001_2345;
        op_b = 32'h0000_0010;
        start_mult = 1'b1;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("pre-reset busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        check("async hi", {32'd0, hi}, 64'd0);
        check("async lo", {32'd0, lo}, 64'd0);
        check("async flags", {61'd0, busy, done, div_zero}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("post-reset quiet", 64'(dones), 64'd0);

        run_op("div 100/7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
